// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding and slice width.
package alu_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : alu_pkg

// File: rtl/nibble_csel_slice.sv
// Combinational 4-bit carry-select adder slice.
// Two ripple chains are evaluated in parallel, one assuming a carry-in of 0 and one
// assuming 1. The real carry-in then picks the matching sum and carry-out.
// Ports:
//   sum  [3:0] out  slice sum
//   cout       out  slice carry-out
//   cin        in   slice carry-in
//   a, b [3:0] in   slice operands
module nibble_csel_slice
  import alu_pkg::*;
(
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  input  logic                cin,
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b
);

  logic [NIBBLE_W:0]   c0;
  logic [NIBBLE_W:0]   c1;
  logic [NIBBLE_W-1:0] s0;
  logic [NIBBLE_W-1:0] s1;

  // Speculative ripple chains, one for each possible carry-in value.
  always_comb begin
    c0    = '0;
    c1    = '0;
    s0    = '0;
    s1    = '0;
    c0[0] = 1'b0;
    c1[0] = 1'b1;
    for (int i = 0; i < int'(NIBBLE_W); i++) begin
      s0[i]   = a[i] ^ b[i] ^ c0[i];
      c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
      s1[i]   = a[i] ^ b[i] ^ c1[i];
      c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
    end
  end

  // Carry-in selects the precomputed result.
  always_comb begin
    sum  = cin ? s1 : s0;
    cout = cin ? c1[NIBBLE_W] : c0[NIBBLE_W];
  end

endmodule : nibble_csel_slice

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract sequencer built around one 4-bit carry-select slice.
// One nibble is processed per clock, LSB nibble first, with the carry registered between
// nibbles. Start/done handshake toward the CPU control unit.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   start           operation request, sampled only when idle
//   sub             0: a+b+cin, 1: a-b (cin ignored)
//   cin             carry-in for add
//   a, b [WIDTH]    operands, sampled with an accepted start
//   busy            high while running or signalling done
//   done            one-cycle pulse, result valid
//   sum  [WIDTH]    result, held until the next accepted start
//   cout            carry out of MSB nibble (sub: 1 = no borrow)
//   overflow        signed overflow of the operation
module nibble_serial_adder_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned LAST    = NIBBLES - 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [NIBBLE_W-1:0] slice_a_c;
  logic [NIBBLE_W-1:0] slice_b_c;
  logic [NIBBLE_W-1:0] slice_sum_c;
  logic                slice_cout_c;
  logic                last_nib_c;

  // Current nibble of each operand feeds the shared slice.
  always_comb begin
    slice_a_c  = opa_q[NIBBLE_W*idx_q +: NIBBLE_W];
    slice_b_c  = opb_q[NIBBLE_W*idx_q +: NIBBLE_W];
    last_nib_c = (idx_q == IDX_W'(LAST));
  end

  nibble_csel_slice u_slice (
    .sum  (slice_sum_c),
    .cout (slice_cout_c),
    .cin  (carry_q),
    .a    (slice_a_c),
    .b    (slice_b_c)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          // Subtract is a + ~b + 1, so the inversion and forced carry happen at capture.
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      ST_RUN: begin
        sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = slice_sum_c;
        carry_d = slice_cout_c;
        idx_d   = idx_q + IDX_W'(1);
        if (last_nib_c) begin
          state_d = ST_DONE;
          cout_d  = slice_cout_c;
          // Same-sign operands producing a result of the other sign.
          ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                    (slice_sum_c[NIBBLE_W-1] != opa_q[WIDTH-1]);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake flags follow the next state so they line up with it in time.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule : nibble_serial_adder_ctrl
